rv32i_dmem_responder: RTL and testbench

// - Data-memory responder: the target end of the core's load/store request channel.
// - Serves one word-wide request at a time: byte-enable writes and full-word reads.
// - Models configurable wait states and returns error responses. Sits between the LSU and on-chip data RAM.
// - Returns the raw 32-bit word. The LSU does byte/half extraction and sign extension.

---
 rtl/rv32i_dmem_responder_pkg.sv | 37 +++
 rtl/rv32i_dmem_responder_if.sv | 26 ++
 rtl/rv32i_dmem_responder_array.sv | 58 +++++
 rtl/rv32i_dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared types and helpers for the RV32I data-memory responder.
// Request/response records, FSM encoding and the byte-enable legality check.
package rv32i_dmem_responder_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = 4;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            we;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } dmem_req_t;

   typedef struct packed {
      logic [XLEN-1:0] rdata;
      logic            err;
   } dmem_rsp_t;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

   // Only naturally aligned byte, half and word lane patterns are legal.
   function automatic logic be_is_legal(logic [3:0] be);
      logic legal;
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
         default:                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// Load/store request channel between the LSU (master) and the data-memory responder (slave).
interface rv32i_dmem_responder_if;
   import rv32i_dmem_responder_pkg::*;

   logic            req_valid_i;
   logic            req_ready_o;
   logic [XLEN-1:0] req_addr_i;
   logic            req_we_i;
   logic [BE_W-1:0] req_be_i;
   logic [XLEN-1:0] req_wdata_i;
   logic            rsp_valid_o;
   logic            rsp_ready_i;
   logic [XLEN-1:0] rsp_rdata_o;
   logic            rsp_err_o;

   modport master (
      output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

endinterface

// File: rtl/rv32i_dmem_responder_array.sv
// Single-port synchronous data RAM with per-byte write mask; one access per cycle.
// A write access (or a masked-off one) clears the read register so the response word reads 0.
module rv32i_dmem_array
   import rv32i_dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   input  logic                           we_i,
   input  logic [BE_W-1:0]                be_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
   input  logic [XLEN-1:0]                wdata_i,
   output logic [XLEN-1:0]                rdata_o
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] rdata_d;

   // Byte-masked write port; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_i[b]) begin
               mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Next read-register value.
   always_comb begin
      rdata_d = rdata_q;
      if (en_i) begin
         if (we_i) begin
            rdata_d = 32'h0000_0000;
         end else begin
            rdata_d = mem[idx_i];
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Read register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= 32'h0000_0000;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder: accepts one LSU request at a time, inserts LATENCY wait
// states, commits the access to the RAM on entry to RESP and presents the response.
module rv32i_dmem_responder
   import rv32i_dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   rv32i_dmem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_e     state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   dmem_req_t       req_q, req_d;
   logic            err_q, err_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;

   dmem_req_t       in_req_s, acc_req_s;
   dmem_rsp_t       rsp_s;
   logic            in_err_s, acc_err_s, accept_s, commit_s;
   logic [XLEN-1:0] acc_off_s;
   logic            ram_en_s, ram_we_s;
   logic [BE_W-1:0] ram_be_s;
   logic [AW-1:0]   ram_idx_s;
   logic [XLEN-1:0] ram_rdata_s;

   // Unsigned offset, so addresses below the base wrap to out of range.
   function automatic logic addr_out_of_range(logic [XLEN-1:0] addr);
      logic [XLEN-1:0] off;
      off = addr - BASE_ADDR;
      return (off >> (AW + 2)) != 32'd0;
   endfunction

   assign bus.req_ready_o = (state_q == DMEM_IDLE) && !rst_i;

   // Incoming request and its fault classification.
   always_comb begin
      in_req_s = '{addr: bus.req_addr_i, we: bus.req_we_i, be: bus.req_be_i, wdata: bus.req_wdata_i};
      in_err_s = addr_out_of_range(bus.req_addr_i) || !be_is_legal(bus.req_be_i);
      accept_s = bus.req_valid_i && bus.req_ready_o;
   end

   // FSM next-state, wait counter and response flags.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      commit_s    = 1'b0;
      case (state_q)
         DMEM_IDLE: begin
            if (accept_s) begin
               req_d = in_req_s;
               err_d = in_err_s;
               if (LATENCY == 0) begin
                  state_d  = DMEM_RESP;
                  commit_s = 1'b1;
               end else begin
                  cnt_d   = 4'(LATENCY - 1);
                  state_d = DMEM_WAIT;
               end
            end else begin
               state_d = DMEM_IDLE;
            end
         end
         DMEM_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d  = DMEM_RESP;
               commit_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DMEM_RESP: begin
            // First RESP cycle lets the synchronous RAM read settle before valid rises.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
            end else if (bus.rsp_ready_i) begin
               state_d     = DMEM_IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = DMEM_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // RAM access: with zero latency the access uses the request straight off the bus.
   always_comb begin
      if (state_q == DMEM_IDLE) begin
         acc_req_s = in_req_s;
         acc_err_s = in_err_s;
      end else begin
         acc_req_s = req_q;
         acc_err_s = err_q;
      end
      acc_off_s = acc_req_s.addr - BASE_ADDR;
      ram_idx_s = AW'(acc_off_s >> 2);
      ram_en_s  = commit_s && !rst_i;
      ram_we_s  = acc_req_s.we || acc_err_s;
      if (acc_err_s || !acc_req_s.we) begin
         ram_be_s = 4'b0000;
      end else begin
         ram_be_s = acc_req_s.be;
      end
   end

   // State, counter, request latch and response flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= DMEM_IDLE;
         cnt_q       <= 4'd0;
         req_q       <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   rv32i_dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (ram_en_s),
      .we_i    (ram_we_s),
      .be_i    (ram_be_s),
      .idx_i   (ram_idx_s),
      .wdata_i (acc_req_s.wdata),
      .rdata_o (ram_rdata_s)
   );

   always_comb begin
      rsp_s = '{rdata: ram_rdata_s, err: rsp_err_q};
   end

   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_rdata_o = rsp_s.rdata;
   assign bus.rsp_err_o   = rsp_s.err;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Bench for rv32i_dmem_responder: LATENCY=2 and LATENCY=0 instances checked every cycle
// against a transaction-level memory model, plus directed literal expectations.
module tb_rv32i_dmem_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rv32i_dmem_responder_if bus_a ();
   rv32i_dmem_responder_if bus_b ();

   rv32i_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_l2 (
      .clk_i (clk), .rst_i (rst), .bus (bus_a));
   rv32i_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut_l0 (
      .clk_i (clk), .rst_i (rst), .bus (bus_b));

   logic [1:0]  d_valid  = 2'b00;
   logic [1:0]  d_we     = 2'b00;
   logic [1:0]  d_rready = 2'b11;
   logic [31:0] d_addr  [2];
   logic [31:0] d_wdata [2];
   logic [3:0]  d_be    [2];
   logic [1:0]  o_valid, o_ready, o_err;
   logic [31:0] o_rdata [2];

   assign bus_a.req_valid_i = d_valid[0];
   assign bus_a.req_addr_i  = d_addr[0];
   assign bus_a.req_we_i    = d_we[0];
   assign bus_a.req_be_i    = d_be[0];
   assign bus_a.req_wdata_i = d_wdata[0];
   assign bus_a.rsp_ready_i = d_rready[0];
   assign bus_b.req_valid_i = d_valid[1];
   assign bus_b.req_addr_i  = d_addr[1];
   assign bus_b.req_we_i    = d_we[1];
   assign bus_b.req_be_i    = d_be[1];
   assign bus_b.req_wdata_i = d_wdata[1];
   assign bus_b.rsp_ready_i = d_rready[1];
   assign o_valid = {bus_b.rsp_valid_o, bus_a.rsp_valid_o};
   assign o_ready = {bus_b.req_ready_o, bus_a.req_ready_o};
   assign o_err   = {bus_b.rsp_err_o,   bus_a.rsp_err_o};
   assign o_rdata[0] = bus_a.rsp_rdata_o;
   assign o_rdata[1] = bus_b.rsp_rdata_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Transaction-level model: one outstanding request per instance, committed to mm at its commit edge.
   bit          pend  [2];
   int          due   [2];
   logic        p_we  [2];
   logic        p_err [2];
   int          p_idx [2];
   logic [3:0]  p_be  [2];
   logic [31:0] p_wd  [2];
   logic [31:0] e_rd  [2];
   logic        e_err [2];
   logic [31:0] mm    [2][1024];

   function automatic int lat_of(int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic logic [31:0] pat(int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(int k);
      string tag;
      bit ev;
      logic [31:0] off;
      tag = (k == 0) ? "L2" : "L0";
      if (rst) begin
         chk({tag, " rst_valid"}, 32'(o_valid[k]), 32'd0);
         chk({tag, " rst_ready"}, 32'(o_ready[k]), 32'd0);
         chk({tag, " rst_rdata"}, o_rdata[k], 32'd0);
         chk({tag, " rst_err"},   32'(o_err[k]), 32'd0);
         pend[k] = 1'b0;
      end else begin
         ev = pend[k] && (cyc >= due[k]);
         chk({tag, " rsp_valid"}, 32'(o_valid[k]), 32'(ev));
         chk({tag, " req_ready"}, 32'(o_ready[k]), 32'(!pend[k]));
         if (ev) begin
            chk({tag, " rsp_rdata"}, o_rdata[k], e_rd[k]);
            chk({tag, " rsp_err"},   32'(o_err[k]), 32'(e_err[k]));
         end
         if (ev && d_rready[k]) begin
            pend[k] = 1'b0;
         end else if (!pend[k] && d_valid[k]) begin
            off      = d_addr[k];
            pend[k]  = 1'b1;
            due[k]   = cyc + lat_of(k) + 2;
            p_we[k]  = d_we[k];
            p_be[k]  = d_be[k];
            p_wd[k]  = d_wdata[k];
            p_err[k] = (off >= 32'd4096) ||
                       !(d_be[k] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
            p_idx[k] = p_err[k] ? 0 : int'(off >> 2);
         end
         if (pend[k] && (due[k] - 1 == cyc + 1)) begin
            if (!p_err[k] && p_we[k]) begin
               for (int b = 0; b < 4; b++) begin
                  if (p_be[k][b]) mm[k][p_idx[k]][8*b +: 8] = p_wd[k][8*b +: 8];
               end
            end
            e_rd[k]  = (p_we[k] || p_err[k]) ? 32'd0 : mm[k][p_idx[k]];
            e_err[k] = p_err[k];
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         step(0);
         step(1);
      end
   end

   // Called just after a rising edge; returns just after the edge that retires the response.
   task automatic txn(input int k, input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
      bit got;
      rd = 32'd0; er = 1'b0; lat = -1;
      d_addr[k] = addr; d_we[k] = we; d_be[k] = be; d_wdata[k] = wd;
      d_rready[k] = (hold == 0);
      d_valid[k] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (o_ready[k]) got = 1'b1;
         else @(posedge clk);
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL req_ready_timeout dut=%0d actual=0 expected=1", k);
         d_valid[k] = 1'b0; d_rready[k] = 1'b1;
         return;
      end
      @(posedge clk); #1;
      d_valid[k] = 1'b0;
      lat = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (o_valid[k]) got = 1'b1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL rsp_valid_timeout dut=%0d actual=0 expected=1", k);
         d_rready[k] = 1'b1;
         return;
      end
      rd = o_rdata[k];
      er = o_err[k];
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", 32'(o_valid[k]), 32'd1);
            chk("hold_ready", 32'(o_ready[k]), 32'd0);
         end
         @(posedge clk); #1;
         d_rready[k] = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   logic [31:0] t_rd;
   logic        t_er;
   int          t_lat;
   logic [3:0]  legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

   initial begin
      for (int k = 0; k < 2; k++) begin
         d_addr[k] = 32'd0; d_wdata[k] = 32'd0; d_be[k] = 4'd0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i <= 17; i++) begin
            int w;
            w = (i == 17) ? 1023 : i;
            txn(k, 32'(w * 4), 1'b1, 4'hF, pat(w), 0, t_rd, t_er, t_lat);
         end
      end

      txn(0, 32'h10, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0, t_rd, t_er, t_lat);
      chk("wr10_lat", 32'(t_lat), 32'd3);
      chk("wr10_err", 32'(t_er), 32'd0);
      chk("wr10_rdata", t_rd, 32'd0);
      txn(0, 32'h10, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rd10_full", t_rd, 32'hDEAD_BEEF);
      txn(0, 32'h13, 1'b1, 4'b1000, 32'hAA00_0000, 0, t_rd, t_er, t_lat);
      txn(0, 32'h10, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rd10_byte", t_rd, 32'hAAAD_BEEF);
      txn(0, 32'h10, 1'b1, 4'b0011, 32'h0000_1234, 0, t_rd, t_er, t_lat);
      txn(0, 32'h10, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rd10_half", t_rd, 32'hAAAD_1234);

      txn(0, 32'h1000, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rd1000_err", 32'(t_er), 32'd1);
      chk("rd1000_rdata", t_rd, 32'd0);
      chk("rd1000_lat", 32'(t_lat), 32'd3);
      txn(0, 32'h1000, 1'b1, 4'b1111, 32'h1234_5678, 0, t_rd, t_er, t_lat);
      chk("wr1000_err", 32'(t_er), 32'd1);
      txn(0, 32'hFFC, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rdffc_err", 32'(t_er), 32'd0);
      chk("rdffc_rdata", t_rd, 32'hC0DE_03FF);

      txn(0, 32'h20, 1'b1, 4'b0101, 32'hFFFF_FFFF, 0, t_rd, t_er, t_lat);
      chk("wr20_be0101_err", 32'(t_er), 32'd1);
      txn(0, 32'h20, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rd20_unchanged", t_rd, 32'hC0DE_0008);
      txn(0, 32'h20, 1'b0, 4'b0000, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rd20_be0000_err", 32'(t_er), 32'd1);

      txn(0, 32'h10, 1'b0, 4'b1111, 32'd0, 5, t_rd, t_er, t_lat);
      chk("hold_rdata", t_rd, 32'hAAAD_1234);
      @(negedge clk);
      chk("hold_release_ready", 32'(o_ready[0]), 32'd1);
      @(posedge clk); #1;

      d_addr[0] = 32'h30; d_we[0] = 1'b1; d_be[0] = 4'hF; d_wdata[0] = 32'h1111_1111;
      d_rready[0] = 1'b1; d_valid[0] = 1'b1;
      @(negedge clk);
      chk("rst_pre_ready", 32'(o_ready[0]), 32'd1);
      @(posedge clk); #1;
      d_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 32'(o_valid[0]), 32'd0);
      chk("rst_async_ready", 32'(o_ready[0]), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      txn(0, 32'h30, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("rd30_after_rst", t_rd, 32'hC0DE_000C);

      txn(1, 32'h40, 1'b1, 4'b1111, 32'h5A5A_A5A5, 0, t_rd, t_er, t_lat);
      chk("l0_wr_lat", 32'(t_lat), 32'd1);
      chk("l0_wr_err", 32'(t_er), 32'd0);
      txn(1, 32'h40, 1'b0, 4'b1111, 32'd0, 0, t_rd, t_er, t_lat);
      chk("l0_rd_lat", 32'(t_lat), 32'd1);
      chk("l0_rd_data", t_rd, 32'h5A5A_A5A5);

      for (int n = 0; n < 200; n++) begin
         int k, sel;
         logic [31:0] a;
         logic [3:0] be;
         k   = int'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 9));
         if (sel <= 6)      a = 32'($urandom_range(0, 16) * 4);
         else if (sel == 7) a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
         else if (sel == 8) a = 32'hFFFF_FFFC;
         else               a = 32'hFFC;
         a = a | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) be = legal_be[$urandom_range(0, 6)];
         else                           be = 4'($urandom_range(0, 15));
         txn(k, a, 1'($urandom_range(0, 1)), be, $urandom, int'($urandom_range(0, 3)), t_rd, t_er, t_lat);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
